// File: rtl/opc5ls_arb_pkg.sv
// Shared types and constants for the OPC5LS two-master bus arbiter.
// Optional build macro: ARB_FIXED_PRIO_EN (master 0 always wins contention).
package opc5ls_arb_pkg;

   // Index of a bus master (two masters: 0 and 1)
   typedef logic master_idx_t;

   // Default number of locked wait cycles before an access is aborted
   localparam int unsigned TIMEOUT_DEFAULT = 15;

   // Read data returned to a master whose access was aborted
   localparam logic [15:0] ABORT_DATA = 16'hFFFF;

   // Arbiter state: OPEN = grant follows requests, LOCKED = grant held on a waiting access
   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/opc5ls_arb_rr.sv
// Grant decision for the two-master arbiter.
// Held grant while locked, otherwise sole requester or round-robin on contention.
// With ARB_FIXED_PRIO_EN defined, master 0 wins every contention.
module opc5ls_arb_rr
   import opc5ls_arb_pkg::*;
(
   input  logic        req0,
   input  logic        req1,
   input  master_idx_t last_winner,
   input  logic        lock,
   input  master_idx_t lock_idx,
   output master_idx_t grant
);

   // Pick the granted master; idle bus parks on the last winner
   always_comb begin
      grant = last_winner;
      if (lock) begin
         grant = lock_idx;
      end else if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
         grant = 1'b0;
`else
         grant = ~last_winner;
`endif
      end else if (req0) begin
         grant = 1'b0;
      end else if (req1) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/opc5ls_bus_arbiter.sv
// Two-master bus arbiter for OPC5LS cores sharing one memory port.
// Masters stall via clken while the memory is not ready; a waiting access
// locks the grant and is aborted (bus_err, read data 16'hFFFF) after TIMEOUT
// locked wait cycles.  Optional build macro: ARB_FIXED_PRIO_EN.
// Handshake: a master requests with vpa|vda; the access completes in the cycle
// where mem_ready=1 (or on abort), signalled to the master by clken=1.
module opc5ls_bus_arbiter
   import opc5ls_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_vpa,
   input  logic        m0_vda,
   input  logic        m0_rnw,
   input  logic [15:0] m0_address,
   input  logic [15:0] m0_dout,
   output logic [15:0] m0_din,
   output logic        m0_clken,
   input  logic        m1_vpa,
   input  logic        m1_vda,
   input  logic        m1_rnw,
   input  logic [15:0] m1_address,
   input  logic [15:0] m1_dout,
   output logic [15:0] m1_din,
   output logic        m1_clken,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output master_idx_t owner,
   output logic        bus_err,
   output arb_state_t  dbg_state
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   arb_state_t  st_q, st_d;
   master_idx_t lock_idx_q, lock_idx_d;
   master_idx_t lw_q, lw_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        req0, req1, lock;
   master_idx_t grant;
   logic        gnt_req, gnt_rnw, timeout_hit;
   logic [15:0] gnt_addr, gnt_dout;

   assign req0      = m0_vpa | m0_vda;
   assign req1      = m1_vpa | m1_vda;
   assign lock      = (st_q == ST_LOCKED);
   assign dbg_state = st_q;

   opc5ls_arb_rr u_rr (
      .req0        (req0),
      .req1        (req1),
      .last_winner (lw_q),
      .lock        (lock),
      .lock_idx    (lock_idx_q),
      .grant       (grant)
   );

   // Select the granted master's request fields and detect the abort condition
   always_comb begin
      gnt_req  = grant ? req1 : req0;
      gnt_rnw  = grant ? m1_rnw : m0_rnw;
      gnt_addr = grant ? m1_address : m0_address;
      gnt_dout = grant ? m1_dout : m0_dout;
      timeout_hit = lock && gnt_req && !mem_ready && (cnt_q == TIMEOUT_CNT);
   end

   // Memory-side outputs, owner and error pulse; reset forces the quiet values
   always_comb begin
      mem_address = gnt_req ? gnt_addr : 16'h0000;
      mem_wdata   = gnt_req ? gnt_dout : 16'h0000;
      mem_re      = !reset && gnt_req && gnt_rnw;
      mem_we      = !reset && gnt_req && !gnt_rnw && !timeout_hit;
      bus_err     = !reset && timeout_hit;
      owner       = reset ? 1'b0 : grant;
   end

   // Master-side clock enables and read data
   always_comb begin
      m0_clken = 1'b0;
      m0_din   = 16'h0000;
      m1_clken = 1'b0;
      m1_din   = 16'h0000;
      if (!reset) begin
         if (!req0) begin
            m0_clken = 1'b1;
         end else if (grant == 1'b0) begin
            if (mem_ready) begin
               m0_clken = 1'b1;
               m0_din   = mem_rdata;
            end else if (timeout_hit) begin
               m0_clken = 1'b1;
               m0_din   = ABORT_DATA;
            end
         end
         if (!req1) begin
            m1_clken = 1'b1;
         end else if (grant == 1'b1) begin
            if (mem_ready) begin
               m1_clken = 1'b1;
               m1_din   = mem_rdata;
            end else if (timeout_hit) begin
               m1_clken = 1'b1;
               m1_din   = ABORT_DATA;
            end
         end
      end
   end

   // Next-state: lock on a stalled grant, release on completion, abort or dropped request
   always_comb begin
      st_d       = st_q;
      lock_idx_d = lock_idx_q;
      cnt_d      = cnt_q;
      lw_d       = lw_q;
      if (!gnt_req) begin
         st_d  = ST_OPEN;
         cnt_d = 8'd0;
      end else if (mem_ready || timeout_hit) begin
         st_d  = ST_OPEN;
         cnt_d = 8'd0;
         lw_d  = grant;
      end else begin
         st_d       = ST_LOCKED;
         lock_idx_d = grant;
         cnt_d      = lock ? cnt_q + 8'd1 : 8'd0;
      end
   end

   // State register; last winner resets to 1 so master 0 wins the first contention
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q       <= ST_OPEN;
         lock_idx_q <= 1'b0;
         cnt_q      <= 8'd0;
         lw_q       <= 1'b1;
      end else begin
         st_q       <= st_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
         lw_q       <= lw_d;
      end
   end

endmodule

// File: tb/tb_opc5ls_bus_arbiter.sv
// Directed testbench for opc5ls_bus_arbiter (TIMEOUT = 15).
// Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
module tb_opc5ls_bus_arbiter;
   import opc5ls_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_vpa = 0, m0_vda = 0, m0_rnw = 1;
   logic [15:0] m0_address = 0, m0_dout = 0;
   logic [15:0] m0_din;
   logic        m0_clken;
   logic        m1_vpa = 0, m1_vda = 0, m1_rnw = 1;
   logic [15:0] m1_address = 0, m1_dout = 0;
   logic [15:0] m1_din;
   logic        m1_clken;
   logic [15:0] mem_address, mem_wdata, mem_rdata = 0;
   logic        mem_re, mem_we, mem_ready = 0;
   master_idx_t owner;
   logic        bus_err;
   arb_state_t  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   opc5ls_bus_arbiter #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .m0_vpa(m0_vpa), .m0_vda(m0_vda), .m0_rnw(m0_rnw), .m0_address(m0_address),
      .m0_dout(m0_dout), .m0_din(m0_din), .m0_clken(m0_clken),
      .m1_vpa(m1_vpa), .m1_vda(m1_vda), .m1_rnw(m1_rnw), .m1_address(m1_address),
      .m1_dout(m1_dout), .m1_din(m1_din), .m1_clken(m1_clken),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .owner(owner), .bus_err(bus_err), .dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic set_m0(input logic req, input logic rnw, input logic [15:0] addr, input logic [15:0] dout);
      m0_vpa = 1'b0; m0_vda = req; m0_rnw = rnw; m0_address = addr; m0_dout = dout;
   endtask

   task automatic set_m1(input logic req, input logic rnw, input logic [15:0] addr, input logic [15:0] dout);
      m1_vpa = req; m1_vda = 1'b0; m1_rnw = rnw; m1_address = addr; m1_dout = dout;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_m0(1, 1, 16'h0010, 0);
      set_m1(1, 0, 16'h0020, 16'h5555);
      mem_ready = 1'b1;
      @(posedge clk); #1; mid();
      n_checks++; if (m0_clken !== 1'b0) begin n_fail++; $display("FAIL rst_m0_clken got=%h exp=0", m0_clken); end
      n_checks++; if (m1_clken !== 1'b0) begin n_fail++; $display("FAIL rst_m1_clken got=%h exp=0", m1_clken); end
      n_checks++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re got=%h exp=0", mem_re); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%h exp=0", mem_we); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err got=%h exp=0", bus_err); end
      n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL rst_owner got=%h exp=0", owner); end
      set_m0(0, 1, 0, 0);
      set_m1(0, 1, 0, 0);
      mem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      set_m0(1, 1, 16'h0100, 0);
      mem_ready = 1'b1; mem_rdata = 16'h1234;
      mid();
      n_checks++; if (m0_clken !== 1'b1) begin n_fail++; $display("FAIL rd_m0_clken got=%h exp=1", m0_clken); end
      n_checks++; if (m0_din !== 16'h1234) begin n_fail++; $display("FAIL rd_m0_din got=%h exp=1234", m0_din); end
      n_checks++; if (m1_clken !== 1'b1) begin n_fail++; $display("FAIL rd_m1_clken got=%h exp=1", m1_clken); end
      n_checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_strobes got=%b%b exp=10", mem_re, mem_we); end
      n_checks++; if (mem_address !== 16'h0100) begin n_fail++; $display("FAIL rd_mem_address got=%h exp=0100", mem_address); end
      n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL rd_owner got=%h exp=0", owner); end
      tick();
      set_m0(0, 1, 0, 0);
      mem_ready = 1'b0;
      mid();
      n_checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_address !== 16'h0000) begin n_fail++; $display("FAIL idle_mem got=%b%b %h exp=00 0000", mem_re, mem_we, mem_address); end
      tick();
   endtask

   task automatic test_round_robin();
      logic exp_owner [4];
`ifdef ARB_FIXED_PRIO_EN
      exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_owner = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      do_reset();
      set_m0(1, 1, 16'h0A00, 0);
      set_m1(1, 1, 16'h0B00, 0);
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 16'hC000 + 16'(i);
         mid();
         n_checks++; if (owner !== exp_owner[i]) begin n_fail++; $display("FAIL rr_owner[%0d] got=%h exp=%h", i, owner, exp_owner[i]); end
         n_checks++; if (m0_clken !== !exp_owner[i] || m1_clken !== exp_owner[i]) begin n_fail++; $display("FAIL rr_clken[%0d] got=%b%b exp=%b%b", i, m0_clken, m1_clken, !exp_owner[i], exp_owner[i]); end
         n_checks++; if ((exp_owner[i] ? m0_din : m1_din) !== 16'h0000) begin n_fail++; $display("FAIL rr_loser_din[%0d] got=%h exp=0000", i, exp_owner[i] ? m0_din : m1_din); end
         tick();
      end
      set_m0(0, 1, 0, 0);
      set_m1(0, 1, 0, 0);
      mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_wait_write();
      logic exp_m1_clken [4];
      exp_m1_clken = '{1'b0, 1'b0, 1'b0, 1'b1};
      set_m1(1, 0, 16'h0200, 16'hBEEF);
      for (int i = 0; i < 4; i++) begin
         if (i >= 1) set_m0(1, 1, 16'h0300, 0);
         mem_ready = (i == 3);
         mid();
         n_checks++; if (m1_clken !== exp_m1_clken[i]) begin n_fail++; $display("FAIL ww_m1_clken[%0d] got=%h exp=%h", i, m1_clken, exp_m1_clken[i]); end
         n_checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL ww_strobes[%0d] got=%b%b exp=01", i, mem_re, mem_we); end
         n_checks++; if (owner !== 1'b1) begin n_fail++; $display("FAIL ww_owner[%0d] got=%h exp=1", i, owner); end
         n_checks++; if (mem_address !== 16'h0200 || mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL ww_bus[%0d] got=%h/%h exp=0200/BEEF", i, mem_address, mem_wdata); end
         n_checks++; if (m0_clken !== (i == 0)) begin n_fail++; $display("FAIL ww_m0_clken[%0d] got=%h exp=%h", i, m0_clken, (i == 0)); end
         tick();
      end
      set_m1(0, 1, 0, 0);
      mem_ready = 1'b1; mem_rdata = 16'h0F0F;
      mid();
      n_checks++; if (owner !== 1'b0 || m0_clken !== 1'b1 || m0_din !== 16'h0F0F) begin n_fail++; $display("FAIL ww_next got=%h %h %h exp=0 1 0F0F", owner, m0_clken, m0_din); end
      tick();
      set_m0(0, 1, 0, 0);
      mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      set_m0(1, 0, 16'h0400, 16'h1111);
      mem_ready = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         mid();
         n_checks++; if (bus_err !== 1'b0 || m0_clken !== 1'b0 || mem_we !== 1'b1) begin n_fail++; $display("FAIL to_wait[%0d] got err=%h clken=%h we=%h exp 0 0 1", c, bus_err, m0_clken, mem_we); end
         tick();
      end
      mid();
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err got=%h exp=1", bus_err); end
      n_checks++; if (m0_din !== 16'hFFFF) begin n_fail++; $display("FAIL to_m0_din got=%h exp=FFFF", m0_din); end
      n_checks++; if (m0_clken !== 1'b1) begin n_fail++; $display("FAIL to_m0_clken got=%h exp=1", m0_clken); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL to_mem_we got=%h exp=0", mem_we); end
      tick();
      mid();
      n_checks++; if (bus_err !== 1'b0 || m0_clken !== 1'b0 || dbg_state !== ST_OPEN) begin n_fail++; $display("FAIL to_after got err=%h clken=%h st=%h exp 0 0 0", bus_err, m0_clken, dbg_state); end
      tick();
      set_m0(0, 1, 0, 0);
      mid();
      n_checks++; if (bus_err !== 1'b0 || m0_clken !== 1'b1) begin n_fail++; $display("FAIL to_drop got err=%h clken=%h exp 0 1", bus_err, m0_clken); end
      tick();
   endtask

   task automatic test_ready_at_timeout();
      set_m0(1, 1, 16'h0500, 0);
      mem_ready = 1'b0; mem_rdata = 16'h5A5A;
      repeat (16) tick();
      mem_ready = 1'b1;
      mid();
      n_checks++; if (dbg_state !== ST_LOCKED) begin n_fail++; $display("FAIL rat_state got=%h exp=1", dbg_state); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rat_bus_err got=%h exp=0", bus_err); end
      n_checks++; if (m0_clken !== 1'b1 || m0_din !== 16'h5A5A) begin n_fail++; $display("FAIL rat_complete got=%h %h exp=1 5A5A", m0_clken, m0_din); end
      tick();
      set_m0(0, 1, 0, 0);
      mem_ready = 1'b0;
      mid();
      n_checks++; if (dbg_state !== ST_OPEN) begin n_fail++; $display("FAIL rat_idle_state got=%h exp=0", dbg_state); end
      tick();
   endtask

   task automatic test_illegal_drop();
      set_m1(1, 1, 16'h0600, 0);
      mem_ready = 1'b0;
      repeat (3) tick();
      set_m1(0, 1, 0, 0);
      set_m0(1, 1, 16'h0700, 0);
      mem_ready = 1'b1; mem_rdata = 16'h7777;
      mid();
      n_checks++; if (owner !== 1'b1 || m0_clken !== 1'b0 || m0_din !== 16'h0000) begin n_fail++; $display("FAIL drop_held got=%h %h %h exp=1 0 0000", owner, m0_clken, m0_din); end
      n_checks++; if (bus_err !== 1'b0 || m1_clken !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL drop_quiet got=%h %h %h exp=0 1 0", bus_err, m1_clken, mem_re); end
      tick();
      mid();
      n_checks++; if (owner !== 1'b0 || m0_clken !== 1'b1 || m0_din !== 16'h7777) begin n_fail++; $display("FAIL drop_next got=%h %h %h exp=0 1 7777", owner, m0_clken, m0_din); end
      tick();
      set_m0(0, 1, 0, 0);
      mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      set_m0(1, 0, 16'h0800, 16'h2222);
      mem_ready = 1'b0;
      repeat (6) tick();
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (m0_clken !== 1'b0 || m1_clken !== 1'b0) begin n_fail++; $display("FAIL rm_clken got=%b%b exp=00", m0_clken, m1_clken); end
      n_checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || bus_err !== 1'b0 || owner !== 1'b0) begin n_fail++; $display("FAIL rm_outs got=%b%b%b%b exp=0000", mem_we, mem_re, bus_err, owner); end
      n_checks++; if (dbg_state !== ST_OPEN) begin n_fail++; $display("FAIL rm_state got=%h exp=0", dbg_state); end
      tick();
      reset = 1'b0;
      set_m0(1, 1, 16'h0900, 0);
      set_m1(1, 1, 16'h0901, 0);
      mem_ready = 1'b1; mem_rdata = 16'h3333;
      mid();
      n_checks++; if (owner !== 1'b0 || m0_clken !== 1'b1 || m1_clken !== 1'b0) begin n_fail++; $display("FAIL rm_first got=%h %h %h exp=0 1 0", owner, m0_clken, m1_clken); end
      tick();
      set_m1(0, 1, 0, 0);
      set_m0(1, 0, 16'h0A00, 16'h4444);
      mem_ready = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         mid();
         n_checks++; if (bus_err !== (c == 17)) begin n_fail++; $display("FAIL rm_count[%0d] got=%h exp=%h", c, bus_err, (c == 17)); end
         tick();
      end
      set_m0(0, 1, 0, 0);
      tick();
   endtask

   // Test sequence and report
   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_wait_write();
      test_timeout();
      test_ready_at_timeout();
      test_illegal_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
